// File: rtl/pcs_tx_gearbox_32b_pkg.sv
// Shared constants and types for the 10GBASE-R 32-bit transmit gearbox.
package gtype;

    localparam logic [1:0]  SH_DATA    = 2'b10;
    localparam logic [1:0]  SH_CTRL    = 2'b01;
    localparam logic [63:0] IDLE_BLOCK = 64'h1E;
    localparam logic [57:0] SCR_INIT   = 58'h3FF_FFFF_FFFF_FFFF;
    localparam int unsigned GB_PERIOD  = 66;
    localparam int unsigned GB_ACTIVE  = 64;
    localparam int unsigned GB_WIN     = 98;

    typedef enum logic {
        HposFirst  = 1'b0,
        HposSecond = 1'b1
    } hpos_e;

endpackage

// File: rtl/pcs_tx_gearbox_32b_if.sv
// Encoder-to-gearbox half-block handshake.
interface pcs_tx_gearbox_32b_if;

    logic [31:0] din;
    logic [1:0]  ctrl;
    logic        even;
    logic        din_en;
    logic        din_rdy;

    modport master (
        output din, ctrl, even, din_en,
        input  din_rdy
    );

    modport slave (
        input  din, ctrl, even, din_en,
        output din_rdy
    );

endinterface

// File: rtl/pcs_tx_gearbox_32b_scrambler.sv
// Self-synchronous x^58+x^39+1 scrambler, 32 bits per enabled cycle, registered output.
module scrambler_tx_32b
    import gtype::*;
#(
    parameter bit SCRAMBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [57:0] state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [57:0] step_s;
    logic [31:0] scr;

    // state[0] holds the most recently scrambled bit
    always_comb begin
        step_s = state_q;
        scr    = '0;
        for (int i = 0; i < 32; i++) begin
            scr[i] = data_i[i] ^ step_s[38] ^ step_s[57];
            step_s = {step_s[56:0], scr[i]};
        end
        state_d = en_i ? step_s : state_q;
        data_d  = data_q;
        if (en_i) begin
            data_d = SCRAMBLE ? scr : data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR_INIT;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pcs_tx_gearbox_32b.sv
// 10GBASE-R transmit back end: slot control, idle insertion, scrambling and 66:64 gearbox.
module pcs_tx_gearbox_32b
    import gtype::*;
#(
    parameter bit SCRAMBLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    pcs_tx_gearbox_32b_if.slave  blk_if,
    output logic [31:0]          pma_data,
    output logic                 idle_ins,
    output logic                 err_underrun,
    output logic                 err_seq
);

    logic [6:0]  seq_q, seq_d;
    hpos_e       hpos_q, hpos_d;
    logic        ins_pend_q, ins_pend_d;
    logic        idle_ins_q, idle_ins_d;
    logic        err_underrun_q, err_underrun_d;
    logic        err_seq_q, err_seq_d;
    logic        slot;
    logic        take;
    logic [31:0] half;
    logic [1:0]  hdr;

    logic        s1_vld_q, s1_vld_d;
    logic        s1_first_q, s1_first_d;
    logic [1:0]  s1_hdr_q, s1_hdr_d;
    logic [31:0] s1_pay;

    logic [63:0]       res_q, res_d;
    logic [6:0]        r_q, r_d;
    logic [31:0]       pma_q, pma_d;
    logic [GB_WIN-1:0] word;
    logic [GB_WIN-1:0] win;
    logic [6:0]        wlen;
    logic [7:0]        fill;
    logic              unused_win;

    assign slot           = seq_q < 7'(GB_ACTIVE);
    assign blk_if.din_rdy = rst & slot & ~ins_pend_q;
    assign take           = blk_if.din_rdy & blk_if.din_en;

    always_comb begin
        seq_d          = (seq_q == 7'(GB_PERIOD - 1)) ? 7'd0 : seq_q + 7'd1;
        hpos_d         = hpos_q;
        ins_pend_d     = 1'b0;
        idle_ins_d     = 1'b0;
        err_underrun_d = 1'b0;
        err_seq_d      = 1'b0;
        half           = '0;
        hdr            = SH_CTRL;
        if (slot) begin
            hpos_d = (hpos_q == HposFirst) ? HposSecond : HposFirst;
            if (ins_pend_q) begin
                half = IDLE_BLOCK[63:32];
            end else if (hpos_q == HposFirst) begin
                if (blk_if.din_en) begin
                    half = blk_if.din;
                    hdr  = blk_if.ctrl;
                end else begin
                    half       = IDLE_BLOCK[31:0];
                    ins_pend_d = 1'b1;
                    idle_ins_d = 1'b1;
                end
            end else if (blk_if.din_en) begin
                half = blk_if.din;
            end else begin
                err_underrun_d = 1'b1;
            end
            // Mismatch is flagged only; the internal position stays authoritative
            err_seq_d = take & (blk_if.even != (hpos_q == HposFirst));
        end
        s1_vld_d   = slot;
        s1_first_d = slot & (hpos_q == HposFirst);
        s1_hdr_d   = hdr;
    end

    scrambler_tx_32b #(
        .SCRAMBLE (SCRAMBLE)
    ) u_scrambler (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (slot),
        .data_i (half),
        .data_o (s1_pay)
    );

    // New word lands above the residue; the oldest 32 bits leave each cycle
    always_comb begin
        word = '0;
        wlen = '0;
        if (s1_vld_q) begin
            if (s1_first_q) begin
                word[33:0] = {s1_pay, s1_hdr_q};
                wlen       = 7'd34;
            end else begin
                word[31:0] = s1_pay;
                wlen       = 7'd32;
            end
        end
        win   = {34'b0, res_q} | (word << r_q);
        fill  = {1'b0, r_q} + {1'b0, wlen};
        pma_d = win[31:0];
        res_d = win[95:32];
        r_d   = (fill >= 8'd32) ? 7'(fill - 8'd32) : 7'd0;
    end

    assign unused_win = ^win[97:96];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q          <= '0;
            hpos_q         <= HposFirst;
            ins_pend_q     <= 1'b0;
            idle_ins_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            err_seq_q      <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_first_q     <= 1'b0;
            s1_hdr_q       <= '0;
            res_q          <= '0;
            r_q            <= '0;
            pma_q          <= '0;
        end else begin
            seq_q          <= seq_d;
            hpos_q         <= hpos_d;
            ins_pend_q     <= ins_pend_d;
            idle_ins_q     <= idle_ins_d;
            err_underrun_q <= err_underrun_d;
            err_seq_q      <= err_seq_d;
            s1_vld_q       <= s1_vld_d;
            s1_first_q     <= s1_first_d;
            s1_hdr_q       <= s1_hdr_d;
            res_q          <= res_d;
            r_q            <= r_d;
            pma_q          <= pma_d;
        end
    end

    assign pma_data     = pma_q;
    assign idle_ins     = idle_ins_q;
    assign err_underrun = err_underrun_q;
    assign err_seq      = err_seq_q;

endmodule

// File: tb/tb_pcs_tx_gearbox_32b.sv
// Bench: bypass and scrambling instances driven identically, checked against a bit-stream model.
module tb_pcs_tx_gearbox_32b;
    import gtype::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcs_tx_gearbox_32b_if ifa ();
    pcs_tx_gearbox_32b_if ifb ();

    logic [31:0] pma_a, pma_b;
    logic        idle_a, und_a, seq_a;
    logic        idle_b, und_b, seq_b;

    pcs_tx_gearbox_32b #(.SCRAMBLE(1'b0)) u_dut_a (
        .clk          (clk),
        .rst          (rst_n),
        .blk_if       (ifa),
        .pma_data     (pma_a),
        .idle_ins     (idle_a),
        .err_underrun (und_a),
        .err_seq      (seq_a)
    );

    pcs_tx_gearbox_32b #(.SCRAMBLE(1'b1)) u_dut_b (
        .clk          (clk),
        .rst          (rst_n),
        .blk_if       (ifb),
        .pma_data     (pma_b),
        .idle_ins     (idle_b),
        .err_underrun (und_b),
        .err_seq      (seq_b)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc;
    bit          ins_next, e_idle, e_und, e_seq;
    bit          qa[$];
    bit          qb[$];
    bit          sh[$];
    bit          dh[$];
    int unsigned kb;
    int unsigned rdy_cnt, ins_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        sh.delete();
        dh.delete();
        for (int i = 0; i < 58; i++) begin
            sh.push_back(1'b1);
            dh.push_back(1'b1);
        end
        cyc      = 0;
        kb       = 0;
        ins_next = 1'b0;
        e_idle   = 1'b0;
        e_und    = 1'b0;
        e_seq    = 1'b0;
    endtask

    // Scrambled bit = input ^ outputs 39 and 58 positions back; history oldest first
    task automatic scr_bit(input bit in_b, output bit out_b);
        out_b = in_b ^ sh[sh.size() - 39] ^ sh[sh.size() - 58];
        sh.push_back(out_b);
        void'(sh.pop_front());
    endtask

    task automatic drive(input logic en, input logic [31:0] d, input logic [1:0] c,
                         input logic ev);
        ifa.din_en = en;
        ifa.din    = d;
        ifa.ctrl   = c;
        ifa.even   = ev;
        ifb.din_en = en;
        ifb.din    = d;
        ifb.ctrl   = c;
        ifb.even   = ev;
    endtask

    task automatic chk_reset();
        chk("rst_pma_a", pma_a, 32'd0);
        chk("rst_pma_b", pma_b, 32'd0);
        chk1("rst_rdy_a", ifa.din_rdy, 1'b0);
        chk1("rst_rdy_b", ifb.din_rdy, 1'b0);
        chk1("rst_idle_a", idle_a, 1'b0);
        chk1("rst_und_a", und_a, 1'b0);
        chk1("rst_seq_a", seq_a, 1'b0);
        chk1("rst_idle_b", idle_b, 1'b0);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            chk_reset();
            @(posedge clk);
            #1;
        end
        chk_reset();
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    // Check the current cycle's outputs, then present one slot of input and advance
    task automatic step(input logic en, input logic [31:0] d, input logic [1:0] c,
                        input logic ev);
        int unsigned p;
        bit          first, rdy_exp, o;
        logic [31:0] wa, wb, wd, half;
        logic [1:0]  hdr;
        p       = cyc % 66;
        first   = (p % 2 == 0);
        rdy_exp = (p < 64) && !ins_next;
        chk1("din_rdy_a", ifa.din_rdy, rdy_exp);
        chk1("din_rdy_b", ifb.din_rdy, rdy_exp);
        if (ifa.din_rdy === 1'b1) rdy_cnt++;
        chk1("idle_ins_a", idle_a, e_idle);
        chk1("idle_ins_b", idle_b, e_idle);
        chk1("err_underrun_a", und_a, e_und);
        chk1("err_underrun_b", und_b, e_und);
        chk1("err_seq_a", seq_a, e_seq);
        chk1("err_seq_b", seq_b, e_seq);
        if (cyc < 2) begin
            chk("preroll_a", pma_a, 32'd0);
            chk("preroll_b", pma_b, 32'd0);
        end else begin
            for (int i = 0; i < 32; i++) begin
                wa[i] = qa.pop_front();
                wb[i] = qb.pop_front();
            end
            chk("pma_a", pma_a, wa);
            chk("pma_b", pma_b, wb);
            for (int i = 0; i < 32; i++) begin
                if (kb % 66 < 2) begin
                    wd[i] = pma_b[i];
                end else begin
                    wd[i] = pma_b[i] ^ dh[19] ^ dh[0];
                    dh.push_back(pma_b[i]);
                    void'(dh.pop_front());
                end
                kb++;
            end
            chk("descrambled_b", wd, wa);
        end

        drive(en, d, c, ev);
        e_idle = 1'b0;
        e_und  = 1'b0;
        e_seq  = 1'b0;
        if (p < 64) begin
            half = 32'd0;
            hdr  = SH_CTRL;
            if (ins_next) begin
                ins_next = 1'b0;
            end else if (first) begin
                if (en) begin
                    half = d;
                    hdr  = c;
                end else begin
                    half     = 32'h1E;
                    ins_next = 1'b1;
                    e_idle   = 1'b1;
                    ins_cnt++;
                end
            end else if (en) begin
                half = d;
            end else begin
                e_und = 1'b1;
            end
            e_seq = rdy_exp && en && (ev != first);
            if (first) begin
                for (int i = 0; i < 2; i++) begin
                    qa.push_back(hdr[i]);
                    qb.push_back(hdr[i]);
                end
            end
            for (int i = 0; i < 32; i++) begin
                qa.push_back(half[i]);
                scr_bit(half[i], o);
                qb.push_back(o);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rnd_step(input int unsigned under_pct, input int unsigned seqerr_pct);
        logic en, ev;
        logic [1:0] c;
        en = ($urandom_range(0, 99) >= under_pct);
        ev = ((cyc % 66) % 2 == 0);
        if ($urandom_range(0, 99) < seqerr_pct) ev = !ev;
        c = ($urandom_range(0, 1) == 1) ? SH_DATA : SH_CTRL;
        step(en, $urandom, c, ev);
    endtask

    logic [31:0] a5;
    logic [31:0] first_word;

    initial begin
        drive(1'b0, 32'd0, SH_DATA, 1'b0);
        model_reset();
        hold_reset(4);

        // Known first block, then clean random blocks for two periods
        a5         = 32'hA5A5_A5A5;
        first_word = {a5[29:0], SH_DATA};
        for (int n = 0; n < 132; n++) begin
            if (cyc == 2) chk("first_word_a", pma_a, first_word);
            if (cyc == 0) step(1'b1, 32'hA5A5_A5A5, SH_DATA, 1'b1);
            else if (cyc == 1) step(1'b1, 32'h0F0F_0F0F, SH_CTRL, 1'b0);
            else rnd_step(0, 0);
        end

        // Ten periods: directed underruns/sequence error first, then random faults
        for (int per = 0; per < 10; per++) begin
            rdy_cnt = 0;
            ins_cnt = 0;
            for (int k = 0; k < 66; k++) begin
                if (per == 0) begin
                    step(!(k == 10 || k == 21), $urandom,
                         SH_DATA, (k == 31) ? 1'b1 : (k % 2 == 0));
                end else begin
                    rnd_step(5, 5);
                end
            end
            chk("rdy_per_period", rdy_cnt, 32'(64 - ins_cnt));
        end

        // All-zero payload through the scrambler
        for (int k = 0; k < 66; k++) step(1'b1, 32'd0, SH_DATA, (k % 2 == 0));

        // Reset right after a first half has been consumed, then restart cleanly
        for (int k = 0; k < 13; k++) rnd_step(0, 0);
        hold_reset(2);
        for (int k = 0; k < 70; k++) rnd_step(3, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_tx_gearbox_32b.md
# pcs_tx_gearbox_32b

Transmit-side 10GBASE-R PCS back end for the 32-bit datapath. It accepts 64b/66b blocks from the encoder as two 32-bit halves with a 2-bit sync header, scrambles the payload with the self-synchronous x^58+x^39+1 scrambler, and packs the 66-bit blocks into a continuous 32-bit PMA word stream. It is the transmit counterpart of the receive aligner/block-sync chain, and its bit ordering matches what that chain expects.

## Interface
- SCRAMBLE, 1: 1 = scramble the payload; 0 = bypass the scrambler (headers are never scrambled).
- clk  in  1  PCS clock; one PMA word per cycle.
- rst  in  1  asynchronous reset, active-low.
- din  in  32  payload half. Bit 0 is transmitted first.
- ctrl  in  2  sync header, sampled with the first half only. ctrl[0] is transmitted first. Data = 2'b10, control = 2'b01.
- even  in  1  1 = first half of a block. Used only as a sequence check.
- din_en  in  1  din, ctrl and even are valid.
- din_rdy  out  1  the gearbox consumes din this cycle if din_en = 1.
- pma_data  out  32  serial word to the PMA. Bit 0 goes on the line first.
- idle_ins  out  1  one-cycle pulse: an idle block was inserted.
- err_underrun  out  1  one-cycle pulse: the second half was missing.
- err_seq  out  1  one-cycle pulse: even disagreed with the internal half position.

## Operation
- **Period counter.** seq counts 0..65 and wraps.
  - din_rdy = (seq < 64) && !ins_pend.
  - Over each period the gearbox consumes 64 halves (32 blocks = 2112 bits) and emits 66 words (2112 bits).
- **Half position.** The block owns the half position; the hpos flag toggles on every consumed slot.
  - A consumed slot is any slot with seq < 64, including inserted slots.
  - On din_en with even != (hpos == first), pulse err_seq. The data is used at the internal position; hpos is not resynchronised.
- **Underrun at a first half** (din_rdy = 1, din_en = 0, hpos = first):
  - Insert an idle control block: header 2'b01, payload 64'h0000_0000_0000_001E.
  - Set ins_pend so din_rdy is low for the second-half slot.
  - Pulse idle_ins.
- **Underrun at a second half:** substitute payload 32'h0 and pulse err_underrun.
- **Scrambler** (stage S1, registered).
  - For each payload bit i, LSB first: out = in ^ s[38] ^ s[57], where s[0] is the most recent scrambled output bit.
  - The 58-bit state advances 32 bits per consumed half. It holds during seq 64/65 and during reset.
  - Reset state is all ones.
  - Header bits bypass the scrambler.
- **Gearbox** (stage S2).
  - Input word w = {payload, header}: 34 bits for a first half, 32 bits for a second half.
  - Combined vector = {w, residue}, where residue is r bits wide and r ≤ 64.
  - pma_data <= combined[31:0]; residue <= the remaining bits.
  - r grows by 2 per block, reaches 64 at the end of the 32nd block, and drains 64→32→0 over seq 64/65, when no word is input.
  - The working window is at most 98 bits. Underflow cannot occur.

## Timing
- Reset values: pma_data = 0, din_rdy = 0, all pulses = 0, seq = 0, hpos = first, ins_pend = 0, r = 0, scrambler state = all ones.
- din_rdy = 1 in the first cycle after rst deasserts.
- Latency: a half consumed at cycle t is scrambled at t+1, and its first bits appear on pma_data at t+2.
- Preroll: pma_data = 0 for the first two cycles after reset.
- din_rdy pattern: exactly 64 cycles high, then 2 low, every 66 cycles. It is also low in the slot after an idle insertion.
- din_en while din_rdy = 0 is ignored and raises no error.
- Reset mid-block or mid-period: everything returns immediately to reset values. The partial block is discarded.
- Error and insertion pulses are asserted in the cycle after the offending slot.

## Structure
- Add to package gtype: SH_DATA = 2'b10, SH_CTRL = 2'b01, IDLE_BLOCK = 64'h1E, SCR_INIT = 58'h3FF_FFFF_FFFF_FFFF, GB_PERIOD = 66, GB_ACTIVE = 64.
- Sub-module scrambler_tx_32b: 58-bit state, 32-bit enable-gated step, registered output.
- Top level holds the seq/hpos/ins_pend control and the 98-bit gearbox.

## Test plan
- Hold rst = 0 with random din → pma_data = 0, din_rdy = 0, all pulses 0. Release → din_rdy = 1 on the next cycle, and the first data word appears 2 cycles after the first consumed half.
- SCRAMBLE = 0, data block din = 32'hA5A5_A5A5 / 32'h0F0F_0F0F, ctrl = 2'b10 → first word = {30'(A5A5A5A5[29:0]), 2'b10}. Bit-exact check of 64 blocks against a 66b reference serialiser.
- Continuous stream over 10 periods → din_rdy shows 64 high / 2 low per period; halves in × 32 + headers = words out × 32; residue returns to 0 at seq = 0.
- din_en = 0 at a first-half slot → a block with header 2'b01 and payload 64'h1E is serialised; din_rdy is low in the next slot; one idle_ins pulse.
- din_en = 0 at a second-half slot → err_underrun pulse and zero payload in that half. Separately, even = 1 at a second-half slot → err_seq pulse and the stream is unshifted.
- SCRAMBLE = 1, all-zero data → output matches the x^58+x^39+1 model from seed all-ones; descrambling with the receive chain recovers zeros. Assert rst mid-block → clean restart with the seq and scrambler state reinitialised.
